odo_sbox6_inv_builder: RTL

//  Runtime inverse for the 6-bit Odo small S-box. Accepts a forward permutation (64 entries,

---
 rtl/odo_sbox6_inv_builder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/odo_sbox6_inv_builder.sv
// Runtime inverse builder for the 6-bit Odo small S-box: loads a forward permutation,
// sweeps it once to build and validate the inverse, then serves registered inverse lookups.
module odo_sbox6_inv_builder #(
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [W-1:0] load_idx,
    input  logic [W-1:0] load_val,
    input  logic         commit,
    output logic         busy,
    output logic         table_ok,
    output logic         perm_err,
    input  logic         lk_valid,
    input  logic [W-1:0] lk_in,
    output logic [W-1:0] lk_out,
    output logic         lk_out_valid
);
    localparam int unsigned DEPTH    = 1 << W;
    localparam logic [W-1:0] PTR_LAST = W'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUILD, S_READY, S_ERROR} state_e;

    state_e           state_q, state_d;
    logic [W-1:0]     ptr_q, ptr_d;
    logic [DEPTH-1:0] loaded_q, loaded_d;
    logic [DEPTH-1:0] seen_q, seen_d;
    logic             dup_q, dup_d;
    logic             busy_q, busy_d;
    logic             table_ok_q, table_ok_d;
    logic             perm_err_q, perm_err_d;
    logic             load_ready_q, load_ready_d;
    logic [W-1:0]     lk_out_q, lk_out_d;
    logic             lk_out_valid_q, lk_out_valid_d;

    logic [W-1:0]     fwd_mem [DEPTH];
    logic [W-1:0]     inv_mem [DEPTH];
    logic [W-1:0]     fwd_rd;
    logic             wr_en;
    logic             build_we;

    assign fwd_rd = fwd_mem[ptr_q];

    // Next-state and next-output logic
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        loaded_d       = loaded_q;
        seen_d         = seen_q;
        dup_d          = dup_q;
        busy_d         = busy_q;
        table_ok_d     = table_ok_q;
        perm_err_d     = perm_err_q;
        build_we       = 1'b0;
        wr_en          = load_valid & load_ready_q;

        if (wr_en) begin
            loaded_d[load_idx] = 1'b1;
        end

        case (state_q)
            S_BUILD: begin
                build_we       = 1'b1;
                seen_d[fwd_rd] = 1'b1;
                if (seen_q[fwd_rd]) begin
                    dup_d = 1'b1;
                end
                if (ptr_q == PTR_LAST) begin
                    busy_d = 1'b0;
                    if (dup_q | seen_q[fwd_rd]) begin
                        state_d    = S_ERROR;
                        perm_err_d = 1'b1;
                        table_ok_d = 1'b0;
                    end else begin
                        state_d    = S_READY;
                        table_ok_d = 1'b1;
                    end
                end else begin
                    ptr_d = ptr_q + W'(1);
                end
            end
            default: begin
                // An accepted write always wins over a simultaneous commit
                if (wr_en) begin
                    state_d    = S_IDLE;
                    table_ok_d = 1'b0;
                    perm_err_d = 1'b0;
                end else if (commit) begin
                    table_ok_d = 1'b0;
                    if (!(&loaded_q)) begin
                        state_d    = S_ERROR;
                        perm_err_d = 1'b1;
                    end else begin
                        state_d    = S_BUILD;
                        perm_err_d = 1'b0;
                        busy_d     = 1'b1;
                        ptr_d      = '0;
                        seen_d     = '0;
                        dup_d      = 1'b0;
                    end
                end
            end
        endcase

        load_ready_d   = (state_d != S_BUILD);
        lk_out_valid_d = lk_valid & table_ok_q;
        lk_out_d       = lk_out_valid_d ? inv_mem[lk_in] : lk_out_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            ptr_q          <= '0;
            loaded_q       <= '0;
            seen_q         <= '0;
            dup_q          <= 1'b0;
            busy_q         <= 1'b0;
            table_ok_q     <= 1'b0;
            perm_err_q     <= 1'b0;
            load_ready_q   <= 1'b1;
            lk_out_q       <= '0;
            lk_out_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            loaded_q       <= loaded_d;
            seen_q         <= seen_d;
            dup_q          <= dup_d;
            busy_q         <= busy_d;
            table_ok_q     <= table_ok_d;
            perm_err_q     <= perm_err_d;
            load_ready_q   <= load_ready_d;
            lk_out_q       <= lk_out_d;
            lk_out_valid_q <= lk_out_valid_d;
        end
    end

    // Table storage carries no reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            fwd_mem[load_idx] <= load_val;
        end
        if (build_we) begin
            inv_mem[fwd_rd] <= ptr_q;
        end
    end

    assign load_ready   = load_ready_q;
    assign busy         = busy_q;
    assign table_ok     = table_ok_q;
    assign perm_err     = perm_err_q;
    assign lk_out       = lk_out_q;
    assign lk_out_valid = lk_out_valid_q;

endmodule
